// File: rtl/crypt_pkg.sv
// crypt_pkg: shared definitions for the Rijndael streaming front-end.
//   BYTE_W / ROWS   : byte width and state row count
//   byte_t          : one state byte
//   fsm_state_t     : fill/hold states of the block assembler
//   block_beats()   : number of input beats per block
//   byte_index()    : flat byte position of matrix element [row][col];
//                     shared with the dematrixify streamer so both agree.
package crypt_pkg;

  localparam int BYTE_W = 8;
  localparam int ROWS   = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_t;

  function automatic int block_beats(input int nb, input int in_w);
    return (32 * nb) / in_w;
  endfunction

  // Byte 0 is the least significant byte of the flat block.
  function automatic int byte_index(input int i, input int j);
    return ROWS * j + i;
  endfunction

endpackage

// File: rtl/matrixify_buf.sv
// matrixify_buf: one Rijndael block buffer.
//   clk, rst_n : clock, asynchronous active-low reset (clears the block)
//   wr_en      : write wr_data into beat slot wr_slot this cycle
//   wr_slot    : beat number, 0 = most significant beat
//   wr_data    : beat payload
//   raw        : stored block as a flat vector
//   matrix     : stored block as [row][col] bytes
module matrixify_buf
  import crypt_pkg::*;
#(
  parameter  int NB         = 4,
  parameter  int IN_W       = 32,
  localparam int BLOCK_BITS = 32 * NB,
  localparam int BEATS      = block_beats(NB, IN_W),
  localparam int CNT_W      = $clog2(BEATS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [CNT_W-1:0]             wr_slot,
  input  logic [IN_W-1:0]              wr_data,
  output logic [BLOCK_BITS-1:0]        raw,
  output byte_t [ROWS-1:0][NB-1:0]     matrix
);

  logic [BLOCK_BITS-1:0] raw_d, raw_q;

  // Constant slot positions keep the write mux a plain decoder.
  always_comb begin
    raw_d = raw_q;
    for (int k = 0; k < BEATS; k++) begin
      if (wr_en && (wr_slot == CNT_W'(k))) begin
        raw_d[BLOCK_BITS-1-k*IN_W -: IN_W] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

  assign raw = raw_q;

  always_comb begin
    matrix = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < NB; j++) begin
        matrix[i][j] = raw_q[BYTE_W*byte_index(i, j) +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/stream_matrixify.sv
// stream_matrixify: assembles a Rijndael state block from IN_W-bit beats
// (first beat most significant) and presents it as a 4 x NB byte matrix.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input beat handshake, in_data is the beat
//   flush               : drop the partially filled block
//   out_valid/out_ready : output block handshake
//   out_matrix          : block as [row][col] bytes
//   out_raw             : block as a flat vector
// Build option STREAM_MATRIXIFY_DBUF_EN: two block buffers so the next
// block fills while the previous one is held (full throughput). Without
// it a single buffer alternates between FILL and HOLD.
// in_ready/out_valid are registered; no combinational input-to-output path.
module stream_matrixify
  import crypt_pkg::*;
#(
  parameter int NB   = 4,
  parameter int IN_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0][NB-1:0][7:0]      out_matrix,
  output logic [32*NB-1:0]             out_raw
);

  localparam int BLOCK_BITS = 32 * NB;
  localparam int BEATS      = block_beats(NB, IN_W);
  localparam int CNT_W      = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             in_ready_d, in_ready_q;
  logic             out_valid_d, out_valid_q;
  logic             take;
  logic             last_beat;

  // flush wins over a same-cycle beat
  assign take      = in_valid && in_ready_q && !flush;
  assign last_beat = take && (cnt_q == LAST);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

`ifdef STREAM_MATRIXIFY_DBUF_EN

  logic       wr_ptr_d, wr_ptr_q;
  logic       rd_ptr_d, rd_ptr_q;
  logic [1:0] occ_d, occ_q;
  logic       pop;
  logic [1:0] wr_en;
  logic [1:0][BLOCK_BITS-1:0]          buf_raw;
  byte_t [1:0][ROWS-1:0][NB-1:0]       buf_matrix;

  assign pop = out_valid_q && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (take) begin
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end
    // Completion and consumption in the same cycle cancel in occupancy.
    occ_d       = occ_q + {1'b0, last_beat} - {1'b0, pop};
    wr_ptr_d    = wr_ptr_q ^ last_beat;
    rd_ptr_d    = rd_ptr_q ^ pop;
    in_ready_d  = (occ_d != 2'd2);
    out_valid_d = (occ_d != 2'd0);
    wr_en[0]    = take && !wr_ptr_q;
    wr_en[1]    = take && wr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_buf
    matrixify_buf #(
      .NB   (NB),
      .IN_W (IN_W)
    ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[b]),
      .wr_slot (cnt_q),
      .wr_data (in_data),
      .raw     (buf_raw[b]),
      .matrix  (buf_matrix[b])
    );
  end

  assign out_raw    = buf_raw[rd_ptr_q];
  assign out_matrix = buf_matrix[rd_ptr_q];

`else

  fsm_state_t state_d, state_q;
  logic       wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (flush) begin
          cnt_d = '0;
        end else if (take) begin
          wr_en = 1'b1;
          if (last_beat) begin
            cnt_d       = '0;
            state_d     = ST_HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        // flush is ignored here: a held block is never discarded
        if (out_ready) begin
          state_d     = ST_FILL;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_FILL;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  matrixify_buf #(
    .NB   (NB),
    .IN_W (IN_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_slot (cnt_q),
    .wr_data (in_data),
    .raw     (out_raw),
    .matrix  (out_matrix)
  );

`endif

endmodule

// File: tb/tb_stream_matrixify.sv
module tb_stream_matrixify;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // DUT A: NB=4, IN_W=32
  logic                  a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0]           a_in_data;
  logic [3:0][3:0][7:0]  a_out_matrix;
  logic [127:0]          a_out_raw;

  // DUT B: NB=4, IN_W=8
  logic                  b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [7:0]            b_in_data;
  logic [3:0][3:0][7:0]  b_out_matrix;
  logic [127:0]          b_out_raw;

  stream_matrixify #(.NB(4), .IN_W(32)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_matrix(a_out_matrix), .out_raw(a_out_raw)
  );

  stream_matrixify #(.NB(4), .IN_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_matrix(b_out_matrix), .out_raw(b_out_raw)
  );

`ifdef STREAM_MATRIXIFY_DBUF_EN
  // DUT C: NB=8, IN_W=32, double buffered
  logic                  c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
  logic [31:0]           c_in_data;
  logic [3:0][7:0][7:0]  c_out_matrix;
  logic [255:0]          c_out_raw;

  stream_matrixify #(.NB(8), .IN_W(32)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_matrix(c_out_matrix), .out_raw(c_out_raw)
  );
`endif

  typedef struct {
    int         i;
    int         j;
    logic [7:0] exp;
  } mvec_t;

  logic [31:0]  blk1 [4];
  logic [31:0]  blka [4];
  mvec_t        mtab [6];
  logic [127:0] blk1_raw, blka_raw;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: handshake timed out, got ready=0 expected ready=1", name);
  endtask

  task automatic a_send(input logic [31:0] d);
    logic ok;
    int   t;
    a_in_valid = 1'b1;
    a_in_data  = d;
    t = 0;
    do begin
      ok = a_in_ready;
      tick();
      t++;
    end while (!ok && t < 50);
    if (!ok) timeout("a_send");
    a_in_valid = 1'b0;
    a_in_data  = 32'hEEEEEEEE;
  endtask

  task automatic b_send(input logic [7:0] d);
    logic ok;
    int   t;
    b_in_valid = 1'b1;
    b_in_data  = d;
    t = 0;
    do begin
      ok = b_in_ready;
      tick();
      t++;
    end while (!ok && t < 50);
    if (!ok) timeout("b_send");
    b_in_valid = 1'b0;
    b_in_data  = 8'hEE;
  endtask

  task automatic a_send_blk1();
    for (int k = 0; k < 4; k++) a_send(blk1[k]);
  endtask

  task automatic a_send_blka();
    for (int k = 0; k < 4; k++) begin
      a_send(blka[k]);
      if (k == 2) chk("a_blka_not_early", a_out_valid, 1'b0);
    end
  endtask

`ifdef STREAM_MATRIXIFY_DBUF_EN
  task automatic c_send(input logic [31:0] d);
    logic ok;
    int   t;
    c_in_valid = 1'b1;
    c_in_data  = d;
    t = 0;
    do begin
      ok = c_in_ready;
      tick();
      t++;
    end while (!ok && t < 50);
    if (!ok) timeout("c_send");
    c_in_valid = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] snap_m, snap_r;
    logic         exp_ir_hold;
    logic [7:0]   bb;

    blk1 = '{32'h121b1904, 32'h637a1279, 32'h74620d15, 32'h77056458};
    blka = '{32'hA0A1A2A3, 32'hA4A5A6A7, 32'hA8A9AAAB, 32'hACADAEAF};
    blk1_raw = 128'h121b1904_637a1279_74620d15_77056458;
    blka_raw = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    mtab = '{
      '{3, 3, 8'h12}, '{2, 2, 8'h7a}, '{2, 0, 8'h05},
      '{1, 3, 8'h19}, '{1, 1, 8'h0d}, '{0, 0, 8'h58}
    };
`ifdef STREAM_MATRIXIFY_DBUF_EN
    exp_ir_hold = 1'b1;
`else
    exp_ir_hold = 1'b0;
`endif

    a_in_valid = 0; a_in_data = '0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_out_ready = 0;
`ifdef STREAM_MATRIXIFY_DBUF_EN
    c_in_valid = 0; c_in_data = '0; c_flush = 0; c_out_ready = 0;
`endif

    // ---- reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_raw", a_out_raw, '0);
    chk("rst_matrix", a_out_matrix, '0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- block 1 on 32-bit beats, held by backpressure
    for (int k = 0; k < 4; k++) begin
      a_send(blk1[k]);
      if (k == 2) chk("t1_not_early", a_out_valid, 1'b0);
    end
    chk("t1_latency", a_out_valid, 1'b1);
    chk("t1_raw", a_out_raw, blk1_raw);
    for (int t = 0; t < 6; t++)
      chk($sformatf("t1_m[%0d][%0d]", mtab[t].i, mtab[t].j),
          a_out_matrix[mtab[t].i][mtab[t].j], mtab[t].exp);

    snap_m = a_out_matrix;
    snap_r = a_out_raw;
`ifndef STREAM_MATRIXIFY_DBUF_EN
    a_in_valid = 1'b1;
    a_in_data  = 32'hFFFFFFFF;
`endif
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_matrix_stable", a_out_matrix, snap_m);
      chk("bp_raw_stable", a_out_raw, snap_r);
      chk("bp_in_ready", a_in_ready, exp_ir_hold);
      chk("bp_out_valid", a_out_valid, 1'b1);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("bp_release_in_ready", a_in_ready, 1'b1);
    chk("bp_release_out_valid", a_out_valid, 1'b0);

    // ---- flush after two beats, then a fresh block
    a_send(32'hDEADBEEF);
    a_send(32'hCAFEF00D);
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 32'h11111111;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    a_send_blka();
    chk("flush_out_valid", a_out_valid, 1'b1);
    chk("flush_raw", a_out_raw, blka_raw);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("flush_m[%0d][%0d]", i, j), a_out_matrix[i][j], 8'(8'hAF - (4*j + i)));
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    chk("flush_hold_valid", a_out_valid, 1'b1);
    chk("flush_hold_raw", a_out_raw, blka_raw);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    chk("flush_consumed", a_out_valid, 1'b0);

    // ---- asynchronous reset mid-fill
    for (int k = 0; k < 3; k++) a_send(blk1[k]);
    #1 rst_n = 1'b0;
    #1;
    chk("rstfill_out_valid", a_out_valid, 1'b0);
    chk("rstfill_in_ready", a_in_ready, 1'b1);
    chk("rstfill_raw", a_out_raw, '0);
    tick();
    rst_n = 1'b1;
    a_send_blk1();
    chk("rstfill_next_valid", a_out_valid, 1'b1);
    chk("rstfill_next_raw", a_out_raw, blk1_raw);

    // ---- asynchronous reset mid-hold
    #1 rst_n = 1'b0;
    #1;
    chk("rsthold_out_valid", a_out_valid, 1'b0);
    chk("rsthold_matrix", a_out_matrix, '0);
    chk("rsthold_raw", a_out_raw, '0);
    tick();
    rst_n = 1'b1;
    a_send_blka();
    chk("rsthold_next_valid", a_out_valid, 1'b1);
    chk("rsthold_next_raw", a_out_raw, blka_raw);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;

    // ---- 8-bit beats with gaps, consumer always ready
    b_out_ready = 1'b1;
    for (int m = 0; m < 16; m++) begin
      if (m % 3 == 1) begin
        b_in_valid = 1'b0;
        b_in_data  = 8'h5A;
        tick();
        tick();
      end
      bb = 8'((blk1[m/4] >> (24 - 8*(m%4))) & 32'hFF);
      b_send(bb);
      if (m == 14) chk("b_gap_not_early", b_out_valid, 1'b0);
    end
    chk("b_out_valid", b_out_valid, 1'b1);
    chk("b_raw", b_out_raw, blk1_raw);
    for (int t = 0; t < 6; t++)
      chk($sformatf("b_m[%0d][%0d]", mtab[t].i, mtab[t].j),
          b_out_matrix[mtab[t].i][mtab[t].j], mtab[t].exp);
    tick();
    chk("b_consumed", b_out_valid, 1'b0);
    chk("b_in_ready", b_in_ready, 1'b1);

`ifdef STREAM_MATRIXIFY_DBUF_EN
    begin
      int           stalls;
      int           vcount;
      logic [255:0] blk_x, blk_y;
      stalls = 0;
      vcount = 0;
      blk_x  = '0;
      blk_y  = '0;
      // back-to-back streaming, consumer ready
      c_out_ready = 1'b1;
      c_in_valid  = 1'b1;
      for (int k = 0; k < 16; k++) begin
        c_in_data = 32'h30000000 + 32'(k);
        if (k >= 8) blk_y = {blk_y[223:0], c_in_data};
        if (!c_in_ready) stalls++;
        if (c_out_valid) vcount++;
        tick();
      end
      c_in_valid = 1'b0;
      if (c_out_valid) vcount++;
      chk("c_stream_raw2", c_out_raw, blk_y);
      tick();
      if (c_out_valid) vcount++;
      chk("c_no_stall", 32'(stalls), 32'd0);
      chk("c_two_blocks", 32'(vcount), 32'd2);

      // two blocks with the consumer stalled
      c_out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
        blk_x = {blk_x[223:0], 32'h40000000 + 32'(k)};
        c_send(32'h40000000 + 32'(k));
      end
      chk("c_ready_after_one", c_in_ready, 1'b1);
      chk("c_valid_after_one", c_out_valid, 1'b1);
      for (int k = 0; k < 8; k++) begin
        blk_y = {blk_y[223:0], 32'h50000000 + 32'(k)};
        c_send(32'h50000000 + 32'(k));
      end
      chk("c_ready_after_two", c_in_ready, 1'b0);
      chk("c_first_raw", c_out_raw, blk_x);
      c_out_ready = 1'b1;
      tick();
      chk("c_second_raw", c_out_raw, blk_y);
      chk("c_second_valid", c_out_valid, 1'b1);
      chk("c_ready_reopen", c_in_ready, 1'b1);
      tick();
      chk("c_drained", c_out_valid, 1'b0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_matrixify.md
Name: stream_matrixify

Overview:
- Streaming successor to the combinational matrixify.
- Accepts a Rijndael state block as a sequence of IN_W-bit beats over a valid/ready handshake and assembles the full block.
- Presents the block as a 4 x NB byte matrix over a second valid/ready handshake.
- Sits between the byte/word input interface and the round datapath; NB generalises beyond AES-128 (NB=4) to Rijndael 192/256-bit blocks.

Parameters:
- NB, 4: state columns; BLOCK_BITS = 32*NB; legal values 4, 6, 8.
- IN_W, 32: input beat width; must divide BLOCK_BITS; legal values 8, 32, BLOCK_BITS.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  IN_W  beat; first beat is most significant
- flush  input  1  discard the partially filled block
- out_valid  output  1  assembled matrix valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_matrix  output  8 x [3:0][NB-1:0]  byte matrix, indexed [row][col]
- out_raw  output  BLOCK_BITS  the same block as a flat vector

Behaviour:
- BEATS = BLOCK_BITS/IN_W. The beat counter is $clog2(BEATS)+1 bits wide; the BEATS=1 case is legal.
- Beat k (k=0 first) is written to raw[BLOCK_BITS-1-k*IN_W -: IN_W].
- Mapping: out_matrix[i][j] = out_raw[8*(NB*... see note) ] is defined as out_matrix[i][j] = out_raw[8*(4*j+i) +: 8].
  - The MSB byte of the block lands at [3][NB-1].
  - The LSB byte lands at [0][0].
- FSM, two states:
  - FILL: in_ready=1, out_valid=0. Each accepted beat writes its slot and increments cnt. On acceptance of beat BEATS-1: cnt <= 0, next state HOLD.
  - HOLD: out_valid=1, in_ready=0. out_matrix and out_raw are stable. On the out_valid && out_ready edge, go to FILL.
- Latency: out_valid rises on the cycle after the final beat is accepted. No combinational in-to-out path.
- in_ready and out_valid are pure functions of registered state; no combinational dependence on in_valid or out_ready.
- flush:
  - In FILL: cnt <= 0 and any same-cycle beat is dropped; flush takes priority over acceptance.
  - In HOLD: ignored. A held block is never discarded.
- Stale bytes from a flushed partial block may remain in the raw register. They are fully overwritten before out_valid rises again.
- Reset (async assert, sync-released by the system):
  - state=FILL, cnt=0, raw=0.
  - out_valid=0, in_ready=1, out_matrix all 8'h00.
  - A reset mid-fill or mid-hold discards everything.
- in_data is ignored when in_valid=0. Holding in_valid with ready low is legal and must not advance cnt.

Optional Feature:
- STREAM_MATRIXIFY_DBUF_EN defined:
  - Two block buffers plus write/read pointers and an occupancy count of 0..2.
  - in_ready = (occupancy < 2), so filling the next block continues while one is held.
  - If the last beat completes and a consumer handshake happens in the same cycle, occupancy stays unchanged and the pointers advance.
  - Full-throughput streaming: one block per BEATS cycles.
  - flush affects only the partial fill buffer.
- Undefined: single buffer, behaviour exactly as the FSM above.

Decomposition:
- Shared package crypt_pkg:
  - localparams BYTE_W=8 and ROWS=4.
  - A byte_t typedef.
  - A function block_beats(NB, IN_W).
  - Mapping function byte_index(i,j)=4*j+i, reused by a future dematrixify streamer.
- Natural sub-module: matrixify_buf, one block buffer with a slot write port and matrix/raw read. It is instantiated once, or twice under STREAM_MATRIXIFY_DBUF_EN. The FSM and counters stay in stream_matrixify.

Test Plan:
- NB=4, IN_W=32, beats 12 1b 19 04 | 63 7a 12 79 | 74 62 0d 15 | 77 05 64 58, out_ready=1:
  - out_valid rises 1 cycle after the 4th beat.
  - [3][3]=12, [2][2]=7a, [2][0]=05, [1][3]=19, [1][1]=0d, [0][0]=58.
- IN_W=8, same 16 bytes with in_valid randomly gapped: identical matrix; cnt does not advance on gaps.
- Backpressure: out_ready=0 for 10 cycles after completion.
  - out_matrix stable, in_ready=0, extra beats not taken.
  - Releasing out_ready gives in_ready=1 on the next cycle.
- flush after 2 of 4 beats, then a full new block A0..AF: output equals the new block only. flush asserted in HOLD leaves out_valid=1.
- rst_n pulled low mid-fill (after 3 beats) and mid-hold: out_valid=0 and all bytes 00 immediately (async). The next full block is correct.
- NB=8, IN_W=32 under STREAM_MATRIXIFY_DBUF_EN:
  - Back-to-back blocks with out_ready=1 see no stall.
  - With out_ready=0, in_ready drops only after the second block completes.
